// File: rtl/sf_camera_reader.sv
// Camera pixel capture: syncs PCLK/VSYNC/HREF/D, packs bytes into 32-bit words for a ping-pong FIFO.
// Optional: define SF_CAMERA_READER_PAD_EN to zero-pad and emit partial words at each line end.
module sf_camera_reader #(
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_pix_clk,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_pix_data,
  input  logic [1:0]  i_wr_rdy,
  input  logic [23:0] i_wr_size,
  output logic [1:0]  o_wr_act,
  output logic        o_wr_stb,
  output logic [31:0] o_wr_data,
  output logic        o_captured,
  output logic [15:0] o_line_count,
  output logic [31:0] o_frame_count,
  output logic        o_overflow
);

  localparam int PACK_W = (WORD_BYTES - 1) * 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
  localparam logic [1:0] ST_CAPTURE    = 2'd2;
  localparam logic [1:0] ST_FRAME_DONE = 2'd3;

`ifdef SF_CAMERA_READER_PAD_EN
  function automatic logic [31:0] pad_word(input logic [23:0] pack, input logic [1:0] n);
    case (n)
      2'd1:    pad_word = {pack[7:0], 24'h000000};
      2'd2:    pad_word = {pack[15:0], 16'h0000};
      2'd3:    pad_word = {pack[23:0], 8'h00};
      default: pad_word = 32'h00000000;
    endcase
  endfunction
`endif

  logic [1:0]        pclk_s_q, vsync_s_q, href_s_q;
  logic              pclk_prev_q, vsync_prev_q, href_prev_q;
  logic [7:0]        data_s1_q, data_s2_q, data_s3_q;

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [1:0]        wr_act_q, wr_act_d;
  logic [23:0]       wr_cnt_q, wr_cnt_d;
  logic              wr_stb_q, wr_stb_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              captured_q, captured_d;
  logic [15:0]       line_count_q, line_count_d;
  logic [31:0]       frame_count_q, frame_count_d;
  logic              overflow_q, overflow_d;

  logic              word_vld;
  logic [31:0]       word;

  // Data gets a third stage so it lines up with the edge seen on the synchronized PCLK.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_s_q     <= 2'b00;
      vsync_s_q    <= 2'b00;
      href_s_q     <= 2'b00;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      data_s1_q    <= 8'h00;
      data_s2_q    <= 8'h00;
      data_s3_q    <= 8'h00;
    end else begin
      pclk_s_q     <= {pclk_s_q[0], i_pix_clk};
      vsync_s_q    <= {vsync_s_q[0], i_vsync};
      href_s_q     <= {href_s_q[0], i_href};
      pclk_prev_q  <= pclk_s_q[1];
      vsync_prev_q <= vsync_s_q[1];
      href_prev_q  <= href_s_q[1];
      data_s1_q    <= i_pix_data;
      data_s2_q    <= data_s1_q;
      data_s3_q    <= data_s2_q;
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall, href_fall;
  assign pclk_rise  = pclk_s_q[1] & ~pclk_prev_q;
  assign vsync_rise = vsync_s_q[1] & ~vsync_prev_q;
  assign vsync_fall = ~vsync_s_q[1] & vsync_prev_q;
  assign href_fall  = ~href_s_q[1] & href_prev_q;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    pack_d        = pack_q;
    wr_act_d      = wr_act_q;
    wr_cnt_d      = wr_cnt_q;
    wr_stb_d      = 1'b0;
    wr_data_d     = wr_data_q;
    captured_d    = 1'b0;
    line_count_d  = line_count_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    word_vld      = 1'b0;
    word          = 32'h00000000;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          overflow_d = 1'b0;
          state_d    = ST_WAIT_VSYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_VSYNC: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (vsync_fall) begin
          line_count_d = 16'd0;
          byte_cnt_d   = 2'd0;
          state_d      = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT_VSYNC;
        end
      end
      ST_CAPTURE: begin
        // A byte coinciding with the end of frame is dropped.
        if (vsync_rise) begin
          state_d = ST_FRAME_DONE;
        end else if (pclk_rise && href_s_q[1]) begin
          pack_d = {pack_q[PACK_W-9:0], data_s3_q};
          if (byte_cnt_q == 2'(WORD_BYTES - 1)) begin
            word_vld   = 1'b1;
            word       = {pack_q, data_s3_q};
            byte_cnt_d = 2'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (href_fall) begin
          line_count_d = line_count_q + 16'd1;
          byte_cnt_d   = 2'd0;
`ifdef SF_CAMERA_READER_PAD_EN
          if (byte_cnt_q != 2'd0) begin
            word_vld = 1'b1;
            word     = pad_word(pack_q, byte_cnt_q);
          end else begin
            word_vld = 1'b0;
          end
`endif
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_FRAME_DONE: begin
        captured_d    = 1'b1;
        frame_count_d = frame_count_q + 32'd1;
        state_d       = i_enable ? ST_WAIT_VSYNC : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Buffer ownership: release at frame end or when full, acquire only when none is held.
    if (state_q == ST_FRAME_DONE) begin
      wr_act_d = 2'b00;
    end else if (wr_act_q != 2'b00) begin
      if (wr_cnt_q >= i_wr_size) begin
        wr_act_d = 2'b00;
        if (word_vld) overflow_d = 1'b1;
      end else if (word_vld) begin
        wr_stb_d  = 1'b1;
        wr_data_d = word;
        wr_cnt_d  = wr_cnt_q + 24'd1;
      end else begin
        wr_stb_d = 1'b0;
      end
    end else begin
      if (word_vld) overflow_d = 1'b1;
      if (state_q != ST_IDLE && i_wr_rdy != 2'b00) begin
        wr_act_d = i_wr_rdy[0] ? 2'b01 : 2'b10;
        wr_cnt_d = 24'd0;
      end else begin
        wr_act_d = 2'b00;
      end
    end
  end

  // Main state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      pack_q        <= '0;
      wr_act_q      <= 2'b00;
      wr_cnt_q      <= 24'd0;
      wr_stb_q      <= 1'b0;
      wr_data_q     <= 32'h00000000;
      captured_q    <= 1'b0;
      line_count_q  <= 16'd0;
      frame_count_q <= 32'd0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      pack_q        <= pack_d;
      wr_act_q      <= wr_act_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_stb_q      <= wr_stb_d;
      wr_data_q     <= wr_data_d;
      captured_q    <= captured_d;
      line_count_q  <= line_count_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign o_wr_act      = wr_act_q;
  assign o_wr_stb      = wr_stb_q;
  assign o_wr_data     = wr_data_q;
  assign o_captured    = captured_q;
  assign o_line_count  = line_count_q;
  assign o_frame_count = frame_count_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_sf_camera_reader.sv
// Self-checking bench for sf_camera_reader: directed frame table, hand-written corner
// sequences and random frames scored against a word/buffer reference model.
module tb_sf_camera_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_pix_clk, i_vsync, i_href;
  logic [7:0]  i_pix_data;
  logic [1:0]  i_wr_rdy;
  logic [23:0] i_wr_size;
  logic [1:0]  o_wr_act;
  logic        o_wr_stb;
  logic [31:0] o_wr_data;
  logic        o_captured;
  logic [15:0] o_line_count;
  logic [31:0] o_frame_count;
  logic        o_overflow;

  sf_camera_reader dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_pix_clk(i_pix_clk),
    .i_vsync(i_vsync), .i_href(i_href), .i_pix_data(i_pix_data),
    .i_wr_rdy(i_wr_rdy), .i_wr_size(i_wr_size), .o_wr_act(o_wr_act),
    .o_wr_stb(o_wr_stb), .o_wr_data(o_wr_data), .o_captured(o_captured),
    .o_line_count(o_line_count), .o_frame_count(o_frame_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: a buffer stops advertising ready once it has been taken.
  logic [1:0] rdy_cfg = 2'b00;
  logic [1:0] used = 2'b00;
  logic       used_clr = 1'b0;
  assign i_wr_rdy = rdy_cfg & ~used;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  logic [31:0] got_data[$];
  logic [1:0]  got_act[$];
  int          cap_cnt = 0;
  int          both_cnt = 0;
  logic [1:0]  prev_act = 2'b00;

  always @(negedge clk) begin
    if (used_clr) used = 2'b00;
    else used = used | o_wr_act;
    if (o_wr_stb) begin
      got_data.push_back(o_wr_data);
      got_act.push_back(o_wr_act);
      chk("act_stable_before_stb", {30'd0, o_wr_act}, {30'd0, prev_act});
    end
    if (o_wr_act == 2'b11) both_cnt++;
    if (o_captured) cap_cnt++;
    prev_act = o_wr_act;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame description and reference model.
  logic [7:0]  byte_q[$];
  int          len_q[$];
  logic [31:0] exp_data[$];
  logic [1:0]  exp_act[$];
  logic        model_ovf = 1'b0;
  int          model_fc = 0;

  task automatic fill_lines(input int nlines, input int nbytes, input logic [7:0] base);
    byte_q = {};
    len_q  = {};
    for (int l = 0; l < nlines; l++) begin
      len_q.push_back(nbytes);
      for (int b = 0; b < nbytes; b++) byte_q.push_back(8'(base + 8'(l * nbytes + b)));
    end
  endtask

  task automatic model_frame(input logic [1:0] rdy, input int size);
    int avail[$];
    int cur;
    int cnt;
    int base;
    logic [31:0] w;
    bit keep;
    exp_data = {};
    exp_act  = {};
    if (rdy[0]) avail.push_back(0);
    if (rdy[1]) avail.push_back(1);
    cur = -1;
    cnt = 0;
    if (avail.size() > 0) cur = avail.pop_front();
    base = 0;
    foreach (len_q[l]) begin
      for (int g = 0; g < len_q[l]; g += 4) begin
        w = 32'h0;
        for (int k = 0; k < 4; k++)
          if (g + k < len_q[l]) w[31 - 8*k -: 8] = byte_q[base + g + k];
        keep = (g + 4 <= len_q[l]);
`ifdef SF_CAMERA_READER_PAD_EN
        keep = 1'b1;
`endif
        if (keep) begin
          if (cur >= 0) begin
            exp_data.push_back(w);
            exp_act.push_back((cur == 0) ? 2'b01 : 2'b10);
            cnt++;
            if (cnt == size) begin
              cnt = 0;
              cur = -1;
              if (avail.size() > 0) cur = avail.pop_front();
            end
          end else begin
            model_ovf = 1'b1;
          end
        end
      end
      base += len_q[l];
    end
    model_fc++;
  endtask

  task automatic pix_byte(input logic [7:0] b);
    i_pix_data = b;
    wait_clk(2);
    i_pix_clk = 1'b1;
    wait_clk(3);
    i_pix_clk = 1'b0;
    wait_clk(2);
  endtask

  task automatic run_frame(input logic [1:0] rdy, input int size, input bit toggle, input bit drop_en);
    int base;
    if (toggle) begin
      i_enable = 1'b0;
      wait_clk(4);
      i_enable = 1'b1;
      wait_clk(4);
      model_ovf = 1'b0;
    end
    used_clr = 1'b1;
    wait_clk(2);
    used_clr = 1'b0;
    got_data = {};
    got_act  = {};
    cap_cnt  = 0;
    both_cnt = 0;
    chk("act_before_rdy", {30'd0, o_wr_act}, 32'd0);
    i_wr_size = 24'(size);
    rdy_cfg   = rdy;
    wait_clk(1);
    chk("act_acquire_latency", {30'd0, o_wr_act}, rdy[0] ? 32'd1 : (rdy[1] ? 32'd2 : 32'd0));
    model_frame(rdy, size);
    i_vsync = 1'b0;
    wait_clk(5);
    base = 0;
    foreach (len_q[l]) begin
      i_href = 1'b1;
      wait_clk(2);
      for (int b = 0; b < len_q[l]; b++) pix_byte(byte_q[base + b]);
      wait_clk(2);
      i_href = 1'b0;
      wait_clk(8);
      if (drop_en && l == 0) i_enable = 1'b0;
      base += len_q[l];
    end
    i_vsync = 1'b1;
    rdy_cfg = 2'b00;
    wait_clk(10);
    chk("strobe_count", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk("wr_data", got_data[i], exp_data[i]);
      chk("wr_act_at_stb", {30'd0, got_act[i]}, {30'd0, exp_act[i]});
    end
    chk("captured_pulses", cap_cnt, 32'd1);
    chk("line_count", {16'd0, o_line_count}, len_q.size());
    chk("frame_count", o_frame_count, model_fc);
    chk("overflow", {31'd0, o_overflow}, {31'd0, model_ovf});
    chk("act_released", {30'd0, o_wr_act}, 32'd0);
    chk("act_never_both", both_cnt, 32'd0);
  endtask

  typedef struct {
    int          nlines;
    int          nbytes;
    logic [7:0]  base;
    logic [1:0]  rdy;
    int          size;
    bit          toggle;
    int          exp_nstb;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [1:0]  exp_act_first;
    logic [1:0]  exp_act_last;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2, 8, 8'h00, 2'b01, 64, 1'b1, 4, 32'h00010203, 32'h0C0D0E0F, 2'b01, 2'b01, 1'b0};
    vecs[1] = '{1, 16, 8'h00, 2'b11, 2, 1'b1, 4, 32'h00010203, 32'h0C0D0E0F, 2'b01, 2'b10, 1'b0};
    vecs[2] = '{1, 8, 8'h00, 2'b00, 64, 1'b1, 0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1};
    vecs[3] = '{1, 4, 8'h30, 2'b01, 64, 1'b0, 1, 32'h30313233, 32'h30313233, 2'b01, 2'b01, 1'b1};
`ifdef SF_CAMERA_READER_PAD_EN
    vecs[4] = '{1, 6, 8'hA0, 2'b01, 64, 1'b1, 2, 32'hA0A1A2A3, 32'hA4A50000, 2'b01, 2'b01, 1'b0};
`else
    vecs[4] = '{1, 6, 8'hA0, 2'b01, 64, 1'b1, 1, 32'hA0A1A2A3, 32'hA0A1A2A3, 2'b01, 2'b01, 1'b0};
`endif

    rst = 1'b1;
    i_enable = 1'b0;
    i_pix_clk = 1'b0;
    i_vsync = 1'b1;
    i_href = 1'b0;
    i_pix_data = 8'h00;
    i_wr_size = 24'd64;
    wait_clk(4);
    chk("rst_wr_act", {30'd0, o_wr_act}, 32'd0);
    chk("rst_wr_stb", {31'd0, o_wr_stb}, 32'd0);
    chk("rst_wr_data", o_wr_data, 32'd0);
    chk("rst_captured", {31'd0, o_captured}, 32'd0);
    chk("rst_line_count", {16'd0, o_line_count}, 32'd0);
    chk("rst_frame_count", o_frame_count, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    rst = 1'b0;
    wait_clk(2);

    for (int v = 0; v < 5; v++) begin
      fill_lines(vecs[v].nlines, vecs[v].nbytes, vecs[v].base);
      run_frame(vecs[v].rdy, vecs[v].size, vecs[v].toggle, 1'b0);
      chk("tbl_nstb", got_data.size(), vecs[v].exp_nstb);
      chk("tbl_overflow", {31'd0, o_overflow}, {31'd0, vecs[v].exp_ovf});
      if (vecs[v].exp_nstb > 0 && got_data.size() == vecs[v].exp_nstb) begin
        chk("tbl_first_word", got_data[0], vecs[v].exp_first);
        chk("tbl_last_word", got_data[vecs[v].exp_nstb - 1], vecs[v].exp_last);
        chk("tbl_first_act", {30'd0, got_act[0]}, {30'd0, vecs[v].exp_act_first});
        chk("tbl_last_act", {30'd0, got_act[vecs[v].exp_nstb - 1]}, {30'd0, vecs[v].exp_act_last});
      end
    end

    // Enable dropped mid-frame: the frame still completes, then the block sits idle.
    fill_lines(2, 8, 8'h50);
    run_frame(2'b01, 64, 1'b1, 1'b1);
    chk("drop_en_nstb", got_data.size(), 32'd4);
    used_clr = 1'b1;
    wait_clk(2);
    used_clr = 1'b0;
    rdy_cfg = 2'b01;
    wait_clk(3);
    chk("idle_no_acquire", {30'd0, o_wr_act}, 32'd0);
    rdy_cfg = 2'b00;

    for (int f = 0; f < 8; f++) begin
      int nl;
      int ln;
      logic [1:0] rdy;
      int size;
      bit tog;
      byte_q = {};
      len_q  = {};
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        ln = $urandom_range(1, 12);
        len_q.push_back(ln);
        for (int b = 0; b < ln; b++) byte_q.push_back(8'($urandom));
      end
      rdy  = 2'($urandom_range(0, 3));
      size = $urandom_range(1, 4);
      tog  = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(rdy, size, tog, 1'b0);
    end

    // Reset in the middle of a line.
    i_enable = 1'b0;
    wait_clk(3);
    i_enable = 1'b1;
    used_clr = 1'b1;
    wait_clk(2);
    used_clr = 1'b0;
    i_wr_size = 24'd64;
    rdy_cfg = 2'b01;
    wait_clk(3);
    i_vsync = 1'b0;
    wait_clk(5);
    i_href = 1'b1;
    wait_clk(2);
    for (int b = 0; b < 6; b++) pix_byte(8'(8'h70 + 8'(b)));
    chk("pre_rst_act", {30'd0, o_wr_act}, 32'd1);
    chk("pre_rst_frame_count", o_frame_count, model_fc);
    rst = 1'b1;
    wait_clk(1);
    chk("midrst_wr_act", {30'd0, o_wr_act}, 32'd0);
    chk("midrst_wr_stb", {31'd0, o_wr_stb}, 32'd0);
    chk("midrst_wr_data", o_wr_data, 32'd0);
    chk("midrst_line_count", {16'd0, o_line_count}, 32'd0);
    chk("midrst_frame_count", o_frame_count, 32'd0);
    chk("midrst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("midrst_captured", {31'd0, o_captured}, 32'd0);
    i_href = 1'b0;
    i_vsync = 1'b1;
    rdy_cfg = 2'b00;
    i_enable = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    chk("post_rst_act", {30'd0, o_wr_act}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sf_camera_reader.md
# sf_camera_reader

Pixel-capture stage sitting downstream of the SparkFun camera controller: when the controller raises its reader-enable, this block samples the camera's 8-bit parallel pixel bus (PCLK/VSYNC/HREF/D[7:0]) in the `clk` domain. It packs bytes into 32-bit words and writes them into the write side of a ping-pong FIFO, which the DMA path drains. It reports frame completion back to the controller's `i_captured` input and exposes line/frame counters and an overflow flag for the register file.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes packed per FIFO word (fixed; documented for clarity).

Ports:
- `clk`  in  1  system clock; must be ≥ 4× camera PCLK frequency.
- `rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  capture enable (driven by controller `o_enable_reader`).
- `i_pix_clk`  in  1  camera PCLK, asynchronous, sampled as data.
- `i_vsync`  in  1  camera VSYNC, asynchronous; high = vertical blanking.
- `i_href`  in  1  camera HREF, asynchronous; high = valid pixel bytes.
- `i_pix_data`  in  8  camera data bus, asynchronous.
- `i_wr_rdy`  in  2  ping-pong FIFO buffer-ready flags.
- `i_wr_size`  in  24  words available in an acquired buffer.
- `o_wr_act`  out  2  buffer-active flags; at most one bit set.
- `o_wr_stb`  out  1  one-cycle write strobe.
- `o_wr_data`  out  32  write word; first byte of each group in [31:24].
- `o_captured`  out  1  one-cycle pulse at end of frame.
- `o_line_count`  out  16  HREF falling edges in current/last frame.
- `o_frame_count`  out  32  completed frames since reset.
- `o_overflow`  out  1  sticky: a word was dropped for lack of a buffer.

## Operation
- Every camera input passes through a 2-FF synchronizer. `i_pix_data` gets one extra delay stage so it aligns with the PCLK rising edge detected on the synchronized PCLK (registered previous-value compare).
- State machine:
  - IDLE: wait for `i_enable`. On `i_enable`, clear `o_overflow` and go to WAIT_VSYNC.
  - WAIT_VSYNC: wait for the synchronized VSYNC falling edge. On that edge, clear `o_line_count` and the byte counter, then go to CAPTURE. If `i_enable` drops, return to IDLE immediately.
  - CAPTURE: on a PCLK rising edge with HREF high, shift the byte into the pack register. When the 4th byte arrives, present the word. Each HREF falling edge increments `o_line_count` (wraps at 16 bits). A VSYNC rising edge moves to FRAME_DONE. Dropping `i_enable` does not abort the frame.
  - FRAME_DONE, which lasts one cycle: release the active buffer if any, pulse `o_captured`, increment `o_frame_count` (wraps). Then go to WAIT_VSYNC if `i_enable` is high, else IDLE.
- Buffer handling:
  - When no buffer is active, not in IDLE, and `i_wr_rdy` is nonzero, acquire buffer 0 if `i_wr_rdy[0]`, else buffer 1. Set the matching `o_wr_act` bit and zero the word count.
  - A presented word with an active buffer and count < `i_wr_size` produces an `o_wr_stb` pulse and increments the count.
  - When count reaches `i_wr_size`, drop `o_wr_act`.
  - A presented word with no active buffer is discarded and sets `o_overflow`.
- Partial words (1–3 bytes) at an HREF falling edge are handled per Configuration. The byte counter restarts at 0 for each line.
- A PCLK edge coincident with a VSYNC rising edge: the byte is ignored (frame already ended).

## Timing
- Reset values: `o_wr_act` = 0, `o_wr_stb` = 0, `o_wr_data` = 0, `o_captured` = 0, `o_line_count` = 0, `o_frame_count` = 0, `o_overflow` = 0; state IDLE; pack register and counters = 0.
- Input-to-detect latency: 3 `clk` cycles from the PCLK pin edge.
- `o_wr_stb` asserts the cycle after the 4th byte is latched, for exactly 1 cycle, with `o_wr_data` valid in that cycle.
- Buffer acquisition: `o_wr_act` rises 1 cycle after `i_wr_rdy` is seen nonzero. The first strobe may occur in the cycle after `o_wr_act` rises, never in the same cycle.
- Release: `o_wr_act` falls in the cycle after the strobe that makes count == `i_wr_size`, or in the FRAME_DONE cycle. A buffer with count 0 at FRAME_DONE is also released.
- `o_captured` is high for exactly the FRAME_DONE cycle.
- `rst` mid-frame: all outputs return to reset values next cycle and any active buffer is released; no strobe in that cycle.

## Configuration
- `SF_CAMERA_READER_PAD_EN` defined: at an HREF falling edge with 1–3 bytes pending, the word is zero-padded in its low bytes and presented like a full word (strobe 1 cycle later).
- Undefined: pending partial bytes are discarded at the HREF falling edge; no strobe.

## Test plan
- Enable, 1 frame of 2 lines × 8 bytes 0x00..0x0F, `i_wr_rdy` = 01, `i_wr_size` = 64 → 4 strobes with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; `o_wr_act` 01 then 00 at frame end; `o_captured` pulses once; `o_line_count` = 2; `o_frame_count` = 1.
- `i_wr_size` = 2, `i_wr_rdy` = 11, one 16-byte line → 2 strobes with `o_wr_act` = 01, then 2 strobes with `o_wr_act` = 10; never both bits set.
- `i_wr_rdy` = 00 throughout a 1-line, 8-byte frame → no strobes; `o_overflow` = 1 and stays 1 until the next IDLE→WAIT_VSYNC transition.
- Line of 6 bytes 0xA0..0xA5 → with macro: second word 0xA4A50000; without macro: only 0xA0A1A2A3.
- `i_enable` drops mid-CAPTURE → frame completes, `o_captured` pulses, FSM goes to IDLE. `rst` asserted mid-line → next cycle `o_wr_act` = 0 and counters = 0.
